bit_permute_pipe: RTL and testbench
===================================

# bit_permute_pipe

Parametrised, pipelined successor to the 32-bit combinational bit reverser in the ALU datapath. It accepts a W-bit operand, a mode, and an opaque tag on a valid/ready handshake, and applies one of four permutations: bit reverse, byte reverse, bit reverse within each byte, or pass-through. The result, tag, zero flag and parity flag emerge PIPE cycles later on a matching valid/ready handshake. It sits between the ALU operand mux and the result writeback and sustains one operation per clock.

## Interface
- W, 32: operand width in bits; multiple of 8, ≥ 8.
- PIPE, 2: register stages; ≥ 1.
- TAG_W, 4: width of the pass-through tag; ≥ 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- in_valid  in  1  input operand present.
- in_ready  out  1  block can accept the operand this cycle.
- in_data  in  W  operand.
- in_mode  in  2  0 = bit reverse, 1 = byte reverse, 2 = bit reverse within each byte, 3 = pass-through.
- in_tag  in  TAG_W  opaque tag, returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_data  out  W  permuted operand.
- out_tag  out  TAG_W  tag of this result.
- out_zero  out  1  out_data == 0.
- out_parity  out  1  XOR of all bits of out_data.

## Operation
- Permutations, for i in 0..W-1 and byte k in 0..W/8-1:
  - mode 0: out[i] = in[W-1-i].
  - mode 1: byte k of out = byte (W/8-1-k) of in.
  - mode 2: out[8k+j] = in[8k+7-j] for j in 0..7.
  - mode 3: out = in.
- The permutation and the zero and parity flags are computed combinationally from in_data and in_mode and captured into stage 1. Stages 2..PIPE are pure delay registers.
- Each stage holds a valid bit, data, tag, zero and parity.
- Global advance: adv = !out_valid || out_ready. When adv = 1, every stage shifts one place and stage 1 loads (in_valid && in_ready). When adv = 0, every stage holds.
- in_ready = adv. This is combinational from out_ready and out_valid; there is no combinational path from in_valid.
- Bubbles are not collapsed. An empty stage only advances when adv = 1.
- Outputs are driven directly from stage PIPE.
- Transfer rule: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Output hold: while out_valid = 1 and out_ready = 0, out_data, out_tag, out_zero and out_parity are held stable.

## Timing
- Reset (rst_n = 0 at a clock edge) clears all stage valids, data, tags and flags to 0.
  - After reset: out_valid = 0, out_data = 0, out_tag = 0, out_zero = 0, out_parity = 0, in_ready = 1.
  - Reset mid-stream discards all in-flight results. No partial result appears afterwards.
- Latency: an operand accepted at edge n appears with out_valid = 1 after edge n+PIPE-1. With PIPE = 1 it appears in the cycle immediately after acceptance.
- Throughput: one result per clock while out_ready = 1.
- Stalls: a stall of S cycles delays every in-flight result by exactly S cycles. Order is preserved and no result is lost or duplicated.
- Simultaneous events: when the output is full and out_ready = 1 in the same cycle as in_valid = 1, the result drains and the new operand enters on the same edge.
- in_mode and in_tag are sampled only on an input transfer.

## Structure
- Shared package bit_permute_pkg holds:
  - mode constants MODE_BITREV = 0, MODE_BYTEREV = 1, MODE_BITREV_IN_BYTE = 2, MODE_PASS = 3;
  - the 2-bit mode typedef.
- One combinational sub-module, bit_permute_core, with parameter W and ports data, mode → result, zero, parity.
- The pipeline is a generate loop of PIPE stage registers in the top level.
- Elaboration-time check: W % 8 != 0, W < 8, or PIPE < 1 must produce a fatal error.

## Test plan
- Default parameters, in_data = 32'h000000FF, mode 0, tag 3, out_ready held 1: after 2 cycles out_data = 32'hFF000000, out_tag = 3, out_zero = 0, out_parity = 0.
- Mode 1 with 32'h12345678 → 32'h78563412. Mode 2 with 32'h01024080 → 32'h80400201. Mode 3 with 32'hDEADBEEF → 32'hDEADBEEF. Operands issued on consecutive cycles must produce results on consecutive cycles, in order.
- Flags: in_data = 0 in any mode → out_zero = 1, out_parity = 0. in_data = 32'h00000001 in mode 0 → out_data = 32'h80000000, out_parity = 1.
- Backpressure: stream 8 operands with tags 0..7 while out_ready toggles randomly. Required: all 8 results arrive exactly once and in tag order, and out_data is stable whenever out_valid = 1 and out_ready = 0.
- Reset mid-stream: assert rst_n = 0 for one edge while 2 results are in flight. Required: out_valid = 0 and out_data = 0 after that edge, and no stale result emerges later.
- Instance with W = 8, PIPE = 1: in_data = 8'b00000110, mode 0 → 8'b01100000 one cycle later. Mode 1 → 8'b00000110 (a single byte is unchanged).

Source files
------------

// File: rtl/bit_permute_pkg.sv
// rtl/bit_permute_pkg.sv - mode encoding shared by the bit permutation pipeline
package bit_permute_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_BITREV         = 2'd0;
    localparam mode_t MODE_BYTEREV        = 2'd1;
    localparam mode_t MODE_BITREV_IN_BYTE = 2'd2;
    localparam mode_t MODE_PASS           = 2'd3;

endpackage

// File: rtl/bit_permute_if.sv
// rtl/bit_permute_if.sv - operand/result handshake bundle for bit_permute_pipe
// Input side:  in_valid/in_ready/in_data/in_mode/in_tag
// Output side: out_valid/out_ready/out_data/out_tag/out_zero/out_parity
// slave = the pipeline, master = the producer/consumer around it.
interface bit_permute_if
    import bit_permute_pkg::*;
#(
    parameter int W     = 32,
    parameter int TAG_W = 4
);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    mode_t            in_mode;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_parity;

    modport slave (
        input  in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero, out_parity
    );

    modport master (
        output in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero, out_parity
    );

endinterface

// File: rtl/bit_permute_core.sv
// rtl/bit_permute_core.sv - combinational permutation with zero and parity flags
// data/mode in; result, zero (result == 0), parity (XOR of result) out.
module bit_permute_core
    import bit_permute_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] data,
    input  mode_t        mode,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         parity
);

    localparam int NB = W / 8;

    always_comb begin
        result = '0;
        case (mode)
            MODE_BITREV: begin
                for (int i = 0; i < W; i++) begin
                    result[i] = data[W-1-i];
                end
            end
            MODE_BYTEREV: begin
                for (int k = 0; k < NB; k++) begin
                    result[8*k +: 8] = data[8*(NB-1-k) +: 8];
                end
            end
            MODE_BITREV_IN_BYTE: begin
                for (int k = 0; k < NB; k++) begin
                    for (int j = 0; j < 8; j++) begin
                        result[8*k+j] = data[8*k+7-j];
                    end
                end
            end
            default: begin
                result = data;
            end
        endcase
    end

    assign zero   = ~|result;
    assign parity = ^result;

endmodule

// File: rtl/bit_permute_pipe.sv
// rtl/bit_permute_pipe.sv - pipelined bit/byte permutation with tag and flags
// clk, rst_n : clock and synchronous active-low reset
// bus        : slave side of bit_permute_if (operand in, result out)
module bit_permute_pipe
    import bit_permute_pkg::*;
#(
    parameter int W     = 32,
    parameter int PIPE  = 2,
    parameter int TAG_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    bit_permute_if.slave bus
);

    if ((W % 8 != 0) || (W < 8) || (PIPE < 1)) begin : g_param_check
        $fatal(1, "bit_permute_pipe: W must be a nonzero multiple of 8 and PIPE >= 1");
    end

    logic         adv;
    logic         in_fire;
    logic [W-1:0] core_result;
    logic         core_zero;
    logic         core_parity;

    bit_permute_core #(.W(W)) u_core (
        .data   (bus.in_data),
        .mode   (bus.in_mode),
        .result (core_result),
        .zero   (core_zero),
        .parity (core_parity)
    );

    // Whole pipe moves in lockstep; bubbles are not squeezed out.
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;
    assign in_fire      = bus.in_valid && adv;

    for (genvar s = 0; s < PIPE; s++) begin : g_stage
        logic             vld_d, vld_q;
        logic [W-1:0]     dat_d, dat_q;
        logic [TAG_W-1:0] tag_d, tag_q;
        logic             zero_d, zero_q;
        logic             par_d, par_q;

        logic             src_vld;
        logic [W-1:0]     src_dat;
        logic [TAG_W-1:0] src_tag;
        logic             src_zero;
        logic             src_par;

        if (s == 0) begin : g_head
            // A bubble enters as all-zero so idle stages never carry stale payload.
            assign src_vld  = in_fire;
            assign src_dat  = in_fire ? core_result : '0;
            assign src_tag  = in_fire ? bus.in_tag : '0;
            assign src_zero = in_fire && core_zero;
            assign src_par  = in_fire && core_parity;
        end else begin : g_tail
            assign src_vld  = g_stage[s-1].vld_q;
            assign src_dat  = g_stage[s-1].dat_q;
            assign src_tag  = g_stage[s-1].tag_q;
            assign src_zero = g_stage[s-1].zero_q;
            assign src_par  = g_stage[s-1].par_q;
        end

        always_comb begin
            vld_d  = vld_q;
            dat_d  = dat_q;
            tag_d  = tag_q;
            zero_d = zero_q;
            par_d  = par_q;
            if (adv) begin
                vld_d  = src_vld;
                dat_d  = src_dat;
                tag_d  = src_tag;
                zero_d = src_zero;
                par_d  = src_par;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                dat_q  <= '0;
                tag_q  <= '0;
                zero_q <= 1'b0;
                par_q  <= 1'b0;
            end else begin
                vld_q  <= vld_d;
                dat_q  <= dat_d;
                tag_q  <= tag_d;
                zero_q <= zero_d;
                par_q  <= par_d;
            end
        end
    end

    assign bus.out_valid  = g_stage[PIPE-1].vld_q;
    assign bus.out_data   = g_stage[PIPE-1].dat_q;
    assign bus.out_tag    = g_stage[PIPE-1].tag_q;
    assign bus.out_zero   = g_stage[PIPE-1].zero_q;
    assign bus.out_parity = g_stage[PIPE-1].par_q;

endmodule

// File: tb/tb_bit_permute_pipe.sv
// tb/tb_bit_permute_pipe.sv - directed self-checking bench for bit_permute_pipe
module tb_bit_permute_pipe;

    logic clk;
    logic rst_n;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  m;
        logic [3:0]  t;
        logic [31:0] e;
        logic        z;
        logic        p;
    } vec_t;

    vec_t vecs [7];

    bit_permute_if #(.W(32), .TAG_W(4)) bus_a ();
    bit_permute_if #(.W(8),  .TAG_W(4)) bus_b ();

    bit_permute_pipe #(.W(32), .PIPE(2), .TAG_W(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    bit_permute_pipe #(.W(8), .PIPE(1), .TAG_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total_cnt++; if (bus_a.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus_a.out_valid); else pass_cnt++;
        total_cnt++; if (bus_a.out_data !== 32'h0) $display("FAIL reset_out_data got %h exp 00000000", bus_a.out_data); else pass_cnt++;
        total_cnt++; if (bus_a.out_tag !== 4'h0) $display("FAIL reset_out_tag got %h exp 0", bus_a.out_tag); else pass_cnt++;
        total_cnt++; if (bus_a.out_zero !== 1'b0) $display("FAIL reset_out_zero got %b exp 0", bus_a.out_zero); else pass_cnt++;
        total_cnt++; if (bus_a.out_parity !== 1'b0) $display("FAIL reset_out_parity got %b exp 0", bus_a.out_parity); else pass_cnt++;
        total_cnt++; if (bus_a.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus_a.in_ready); else pass_cnt++;
        total_cnt++; if (bus_b.out_valid !== 1'b0) $display("FAIL reset_b_out_valid got %b exp 0", bus_b.out_valid); else pass_cnt++;
        total_cnt++; if (bus_b.out_data !== 8'h0) $display("FAIL reset_b_out_data got %h exp 00", bus_b.out_data); else pass_cnt++;
        total_cnt++; if (bus_b.in_ready !== 1'b1) $display("FAIL reset_b_in_ready got %b exp 1", bus_b.in_ready); else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_modes();
        vecs[0] = '{32'h000000FF, 2'd0, 4'd3, 32'hFF000000, 1'b0, 1'b0};
        vecs[1] = '{32'h12345678, 2'd1, 4'd5, 32'h78563412, 1'b0, 1'b1};
        vecs[2] = '{32'h01024080, 2'd2, 4'd6, 32'h80400201, 1'b0, 1'b0};
        vecs[3] = '{32'hDEADBEEF, 2'd3, 4'd7, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[4] = '{32'h00000000, 2'd0, 4'd1, 32'h00000000, 1'b1, 1'b0};
        vecs[5] = '{32'h00000000, 2'd2, 4'd2, 32'h00000000, 1'b1, 1'b0};
        vecs[6] = '{32'h00000001, 2'd0, 4'd9, 32'h80000000, 1'b0, 1'b1};
        bus_a.out_ready = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            if (c < 7) begin
                bus_a.in_valid = 1'b1;
                bus_a.in_data  = vecs[c].d;
                bus_a.in_mode  = vecs[c].m;
                bus_a.in_tag   = vecs[c].t;
            end else begin
                bus_a.in_valid = 1'b0;
            end
            step();
            if (c == 0) begin
                total_cnt++; if (bus_a.out_valid !== 1'b0) $display("FAIL latency_early_valid got %b exp 0", bus_a.out_valid); else pass_cnt++;
            end else begin
                total_cnt++; if (bus_a.out_valid !== 1'b1) $display("FAIL mode_valid[%0d] got %b exp 1", c-1, bus_a.out_valid); else pass_cnt++;
                total_cnt++; if (bus_a.out_data !== vecs[c-1].e) $display("FAIL mode_data[%0d] got %h exp %h", c-1, bus_a.out_data, vecs[c-1].e); else pass_cnt++;
                total_cnt++; if (bus_a.out_tag !== vecs[c-1].t) $display("FAIL mode_tag[%0d] got %h exp %h", c-1, bus_a.out_tag, vecs[c-1].t); else pass_cnt++;
                total_cnt++; if (bus_a.out_zero !== vecs[c-1].z) $display("FAIL mode_zero[%0d] got %b exp %b", c-1, bus_a.out_zero, vecs[c-1].z); else pass_cnt++;
                total_cnt++; if (bus_a.out_parity !== vecs[c-1].p) $display("FAIL mode_parity[%0d] got %b exp %b", c-1, bus_a.out_parity, vecs[c-1].p); else pass_cnt++;
            end
        end
        step();
        total_cnt++; if (bus_a.out_valid !== 1'b0) $display("FAIL mode_drain_valid got %b exp 0", bus_a.out_valid); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [15:0] rdy_pat;
        logic [31:0] held_d;
        logic [3:0]  held_t;
        logic [31:0] exp_d;
        logic        hold_pending;
        int          sent;
        int          recv;
        int          cyc;
        rdy_pat      = 16'b0110_1001_1100_1010;
        hold_pending = 1'b0;
        held_d       = '0;
        held_t       = '0;
        sent         = 0;
        recv         = 0;
        cyc          = 0;
        while (recv < 8 && cyc < 200) begin
            bus_a.out_ready = rdy_pat[cyc % 16];
            if (sent < 8) begin
                bus_a.in_valid = 1'b1;
                bus_a.in_data  = 32'h10203040 + 32'(sent);
                bus_a.in_mode  = 2'd1;
                bus_a.in_tag   = 4'(sent);
            end else begin
                bus_a.in_valid = 1'b0;
            end
            #1;
            if (hold_pending) begin
                total_cnt++; if (bus_a.out_data !== held_d) $display("FAIL bp_hold_data got %h exp %h", bus_a.out_data, held_d); else pass_cnt++;
                total_cnt++; if (bus_a.out_tag !== held_t) $display("FAIL bp_hold_tag got %h exp %h", bus_a.out_tag, held_t); else pass_cnt++;
            end
            hold_pending = bus_a.out_valid && !bus_a.out_ready;
            held_d       = bus_a.out_data;
            held_t       = bus_a.out_tag;
            if (bus_a.out_valid && bus_a.out_ready) begin
                exp_d = {8'h40 + 8'(recv), 8'h30, 8'h20, 8'h10};
                total_cnt++; if (bus_a.out_tag !== 4'(recv)) $display("FAIL bp_order_tag got %h exp %h", bus_a.out_tag, 4'(recv)); else pass_cnt++;
                total_cnt++; if (bus_a.out_data !== exp_d) $display("FAIL bp_data got %h exp %h", bus_a.out_data, exp_d); else pass_cnt++;
                recv++;
            end
            if (bus_a.in_valid && bus_a.in_ready) sent++;
            step();
            cyc++;
        end
        total_cnt++; if (recv != 8) $display("FAIL bp_received got %0d exp 8", recv); else pass_cnt++;
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        step();
        step();
        total_cnt++; if (bus_a.out_valid !== 1'b0) $display("FAIL bp_no_duplicate got %b exp 0", bus_a.out_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid_stream();
        int stale;
        bus_a.out_ready = 1'b1;
        bus_a.in_valid  = 1'b1;
        bus_a.in_data   = 32'hCAFE0001;
        bus_a.in_mode   = 2'd3;
        bus_a.in_tag    = 4'hA;
        step();
        bus_a.in_data   = 32'hCAFE0002;
        bus_a.in_tag    = 4'hB;
        step();
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b0;
        total_cnt++; if (bus_a.out_valid !== 1'b1) $display("FAIL rst_mid_in_flight got %b exp 1", bus_a.out_valid); else pass_cnt++;
        rst_n = 1'b0;
        step();
        total_cnt++; if (bus_a.out_valid !== 1'b0) $display("FAIL rst_mid_valid got %b exp 0", bus_a.out_valid); else pass_cnt++;
        total_cnt++; if (bus_a.out_data !== 32'h0) $display("FAIL rst_mid_data got %h exp 00000000", bus_a.out_data); else pass_cnt++;
        total_cnt++; if (bus_a.out_tag !== 4'h0) $display("FAIL rst_mid_tag got %h exp 0", bus_a.out_tag); else pass_cnt++;
        total_cnt++; if (bus_a.in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got %b exp 1", bus_a.in_ready); else pass_cnt++;
        rst_n = 1'b1;
        bus_a.out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            step();
            if (bus_a.out_valid) stale++;
        end
        total_cnt++; if (stale != 0) $display("FAIL rst_mid_stale got %0d exp 0", stale); else pass_cnt++;
    endtask

    task automatic test_narrow();
        bus_b.out_ready = 1'b1;
        bus_b.in_valid  = 1'b1;
        bus_b.in_data   = 8'b0000_0110;
        bus_b.in_mode   = 2'd0;
        bus_b.in_tag    = 4'd1;
        step();
        bus_b.in_mode   = 2'd1;
        bus_b.in_tag    = 4'd2;
        total_cnt++; if (bus_b.out_valid !== 1'b1) $display("FAIL narrow_bitrev_valid got %b exp 1", bus_b.out_valid); else pass_cnt++;
        total_cnt++; if (bus_b.out_data !== 8'b0110_0000) $display("FAIL narrow_bitrev_data got %b exp 01100000", bus_b.out_data); else pass_cnt++;
        total_cnt++; if (bus_b.out_tag !== 4'd1) $display("FAIL narrow_bitrev_tag got %h exp 1", bus_b.out_tag); else pass_cnt++;
        total_cnt++; if (bus_b.out_parity !== 1'b0) $display("FAIL narrow_bitrev_parity got %b exp 0", bus_b.out_parity); else pass_cnt++;
        step();
        bus_b.in_valid  = 1'b0;
        total_cnt++; if (bus_b.out_valid !== 1'b1) $display("FAIL narrow_byterev_valid got %b exp 1", bus_b.out_valid); else pass_cnt++;
        total_cnt++; if (bus_b.out_data !== 8'b0000_0110) $display("FAIL narrow_byterev_data got %b exp 00000110", bus_b.out_data); else pass_cnt++;
        total_cnt++; if (bus_b.out_tag !== 4'd2) $display("FAIL narrow_byterev_tag got %h exp 2", bus_b.out_tag); else pass_cnt++;
        step();
        total_cnt++; if (bus_b.out_valid !== 1'b0) $display("FAIL narrow_drain_valid got %b exp 0", bus_b.out_valid); else pass_cnt++;
    endtask

    initial begin
        pass_cnt        = 0;
        total_cnt       = 0;
        rst_n           = 1'b0;
        bus_a.in_valid  = 1'b0;
        bus_a.in_data   = '0;
        bus_a.in_mode   = 2'd0;
        bus_a.in_tag    = '0;
        bus_a.out_ready = 1'b1;
        bus_b.in_valid  = 1'b0;
        bus_b.in_data   = '0;
        bus_b.in_mode   = 2'd0;
        bus_b.in_tag    = '0;
        bus_b.out_ready = 1'b1;
        #2;
        test_reset();
        test_modes();
        test_backpressure();
        test_reset_mid_stream();
        test_narrow();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
